// File: rtl/accumulator_bank_if.sv
// Input-beat / result bus of accumulator_bank. The master drives beats and
// commands; the slave (the bank) returns ready, results and overflow flags.
interface accumulator_bank_if #(
    parameter int WIDTH = 16,
    parameter int CH_W  = 2
);
    localparam int CHANNELS = 2 ** CH_W;

    logic                in_valid;
    logic                in_ready;
    logic [CH_W-1:0]     in_chan;
    logic [WIDTH-1:0]    in;
    logic                clear;
    logic                dump;
    logic                out_valid;
    logic [CH_W-1:0]     out_chan;
    logic [WIDTH-1:0]    out;
    logic [CHANNELS-1:0] overflow;

    modport master (
        output in_valid, in_chan, in, clear, dump,
        input  in_ready, out_valid, out_chan, out, overflow
    );

    modport slave (
        input  in_valid, in_chan, in, clear, dump,
        output in_ready, out_valid, out_chan, out, overflow
    );
endinterface

// File: rtl/accumulator_bank.sv
// Bank of 2**CH_W unsigned accumulators with sticky overflow and sequential dump.
// Build option: define ACC_SATURATE_EN to clamp overflowing sums instead of wrapping.
//
// state  | meaning
// S_RUN  | accept beats / clears, dump request moves to S_DUMP
// S_DUMP | stream acc[0..CHANNELS-1] one per cycle, inputs ignored
module accumulator_bank #(
    parameter int WIDTH = 16,
    parameter int CH_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    accumulator_bank_if.slave  bus
);
    localparam int CHANNELS = 2 ** CH_W;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DUMP = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready;
    logic                accept;
    logic [CH_W-1:0]     idx_q;
    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [WIDTH-1:0]    out_q;
    logic [CH_W-1:0]     out_chan_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    base;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            S_RUN: begin
                ready = 1'b1;
                if (bus.dump) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (idx_q == CH_W'(CHANNELS - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign accept = bus.in_valid && ready;

    // Clear takes effect before the add when both arrive together.
    assign base = bus.clear ? '0 : acc_q[bus.in_chan];
    assign sum  = {1'b0, base} + {1'b0, bus.in};

`ifdef ACC_SATURATE_EN
    assign result = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign result = sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (accept) begin
                        acc_q[bus.in_chan] <= result;
                        ovf_q[bus.in_chan] <= (ovf_q[bus.in_chan] & ~bus.clear) | sum[WIDTH];
                        out_q              <= result;
                        out_chan_q         <= bus.in_chan;
                        out_valid_q        <= 1'b1;
                    end else if (bus.clear) begin
                        acc_q[bus.in_chan] <= '0;
                        ovf_q[bus.in_chan] <= 1'b0;
                    end
                    if (bus.dump) begin
                        idx_q <= '0;
                    end
                end
                S_DUMP: begin
                    out_q       <= acc_q[idx_q];
                    out_chan_q  <= idx_q;
                    out_valid_q <= 1'b1;
                    idx_q       <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out       = out_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// Directed vector bench for accumulator_bank (WIDTH=16, CH_W=2).
module tb_accumulator_bank;
    localparam int WIDTH = 16;
    localparam int CH_W  = 2;

`ifdef ACC_SATURATE_EN
    localparam logic [15:0] OV1 = 16'hFFFF;
    localparam logic [15:0] OV2 = 16'hFFFF;
`else
    localparam logic [15:0] OV1 = 16'h0010;
    localparam logic [15:0] OV2 = 16'h0003;
`endif

    logic clk = 1'b0;
    logic reset;

    accumulator_bank_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

    accumulator_bank #(.WIDTH(WIDTH), .CH_W(CH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [1:0]  ch;
        logic [15:0] din;
        logic        clr;
        logic        dmp;
        logic        e_v;
        logic [1:0]  e_ch;
        logic [15:0] e_out;
        logic [3:0]  e_ovf;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic addv(input logic rst, input logic iv, input logic [1:0] ch,
                        input logic [15:0] din, input logic clr, input logic dmp,
                        input logic e_v, input logic [1:0] e_ch, input logic [15:0] e_out,
                        input logic [3:0] e_ovf, input logic e_rdy);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ch = ch; v.din = din; v.clr = clr; v.dmp = dmp;
        v.e_v = e_v; v.e_ch = e_ch; v.e_out = e_out; v.e_ovf = e_ovf; v.e_rdy = e_rdy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [1:0] ch,
                         input logic [15:0] din, input logic clr, input logic dmp);
        reset        = rst;
        bus.in_valid = iv;
        bus.in_chan  = ch;
        bus.in       = din;
        bus.clear    = clr;
        bus.dump     = dmp;
    endtask

    initial begin
        int cycles;
        int beats;

        drive(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);

        //    rst iv ch  din       clr dmp   v  ch  out       ovf      rdy
        addv(1, 0, 0, 16'd0,      0, 0,    0, 0, 16'd0,     4'b0000, 1);
        addv(1, 1, 2, 16'd9,      0, 1,    0, 0, 16'd0,     4'b0000, 1);
        addv(0, 1, 0, 16'd5,      0, 0,    1, 0, 16'd5,     4'b0000, 1);
        addv(0, 1, 0, 16'd5,      0, 0,    1, 0, 16'd10,    4'b0000, 1);
        addv(0, 0, 0, 16'd0,      0, 0,    0, 0, 16'd10,    4'b0000, 1);
        addv(0, 1, 1, 16'hFFF0,   0, 0,    1, 1, 16'hFFF0,  4'b0000, 1);
        addv(0, 1, 1, 16'h0020,   0, 0,    1, 1, OV1,       4'b0010, 1);
        addv(0, 0, 1, 16'd0,      0, 0,    0, 1, OV1,       4'b0010, 1);
        addv(0, 1, 1, 16'd7,      1, 0,    1, 1, 16'd7,     4'b0000, 1);
        addv(0, 1, 3, 16'd3,      0, 0,    1, 3, 16'd3,     4'b0000, 1);
        addv(0, 0, 3, 16'd0,      1, 0,    0, 3, 16'd3,     4'b0000, 1);
        // dump with acc = {0,0,7,10}; beats offered during DUMP must be ignored
        addv(0, 0, 0, 16'd0,      0, 1,    0, 3, 16'd3,     4'b0000, 0);
        addv(0, 1, 0, 16'd100,    1, 0,    1, 0, 16'd10,    4'b0000, 0);
        addv(0, 1, 1, 16'd1,      0, 1,    1, 1, 16'd7,     4'b0000, 0);
        addv(0, 1, 2, 16'd2,      0, 0,    1, 2, 16'd0,     4'b0000, 0);
        addv(0, 1, 3, 16'd4,      1, 0,    1, 3, 16'd0,     4'b0000, 1);
        addv(0, 0, 0, 16'd0,      0, 0,    0, 3, 16'd0,     4'b0000, 1);
        // dump together with an accepted beat on ch2
        addv(0, 1, 2, 16'd4,      0, 1,    1, 2, 16'd4,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 0, 16'd10,    4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 1, 16'd7,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 2, 16'd4,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 3, 16'd0,     4'b0000, 1);
        addv(0, 1, 2, 16'hFFFF,   0, 0,    1, 2, OV2,       4'b0100, 1);
        addv(0, 1, 0, 16'd1,      0, 0,    1, 0, 16'd11,    4'b0100, 1);
        // reset in the 2nd DUMP cycle
        addv(0, 0, 0, 16'd0,      0, 1,    0, 0, 16'd11,    4'b0100, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 0, 16'd11,    4'b0100, 0);
        addv(1, 1, 1, 16'd5,      1, 1,    0, 0, 16'd0,     4'b0000, 1);
        addv(0, 0, 0, 16'd0,      0, 1,    0, 0, 16'd0,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 0, 16'd0,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 1, 16'd0,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 2, 16'd0,     4'b0000, 0);
        addv(0, 0, 0, 16'd0,      0, 0,    1, 3, 16'd0,     4'b0000, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ch, vecs[i].din, vecs[i].clr, vecs[i].dmp);
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== vecs[i].e_v || bus.out_chan !== vecs[i].e_ch ||
                bus.out !== vecs[i].e_out || bus.overflow !== vecs[i].e_ovf ||
                bus.in_ready !== vecs[i].e_rdy) begin
                bad++;
                $display("FAIL vec%0d: got v=%b ch=%0d out=%h ovf=%b rdy=%b, want v=%b ch=%0d out=%h ovf=%b rdy=%b",
                         i, bus.out_valid, bus.out_chan, bus.out, bus.overflow, bus.in_ready,
                         vecs[i].e_v, vecs[i].e_ch, vecs[i].e_out, vecs[i].e_ovf, vecs[i].e_rdy);
            end
        end

        // DUMP length: in_ready low for exactly 4 edges, one result beat per edge
        drive(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2'd1, 16'd3, 1'b0, 1'b1);
        cycles = 0;
        beats  = 0;
        while (!bus.in_ready && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid) beats++;
        end
        total++;
        if (cycles != 4 || beats != 4) begin
            bad++;
            $display("FAIL dump_len: got cycles=%0d beats=%0d, want cycles=4 beats=4", cycles, beats);
        end

        // beats offered during that dump must not have reached ch1
        drive(1'b0, 1'b1, 2'd1, 16'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (bus.out !== 16'd2 || bus.out_chan !== 2'd1 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_dump_add: got out=%h ch=%0d v=%b, want out=0002 ch=1 v=1",
                     bus.out, bus.out_chan, bus.out_valid);
        end

        drive(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accumulator_bank.md
ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

Interface
REQ-001 Parameter WIDTH, 16, bit width of data input, each accumulator and output.
REQ-002 Parameter CH_W, 2, channel index width; CHANNELS = 2**CH_W accumulators.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port in_valid  input  1  input beat present.
REQ-006 Port in_ready  output  1  block accepts input; combinational, high only in state RUN.
REQ-007 Port in_chan  input  CH_W  target channel of the input beat.
REQ-008 Port in  input  WIDTH  unsigned addend.
REQ-009 Port clear  input  1  zero the accumulator and overflow flag of in_chan.
REQ-010 Port dump  input  1  request sequential readout of all channels.
REQ-011 Port out_valid  output  1  out/out_chan hold a valid result this cycle.
REQ-012 Port out_chan  output  CH_W  channel of the result on out.
REQ-013 Port out  output  WIDTH  accumulator value.
REQ-014 Port overflow  output  CHANNELS  sticky per-channel overflow flags.

Function
REQ-015 The input SHALL be accepted at a posedge where in_valid && in_ready; acc[in_chan] <= acc[in_chan] + in.
REQ-016 An accepted beat SHALL produce, at that same edge, out <= new acc value, out_chan <= in_chan, out_valid <= 1 (result visible one clock after the input is presented).
REQ-017 out_valid SHALL be 0 after any RUN edge with no accepted beat; out and out_chan SHALL hold their last values.
REQ-018 The addition SHALL be unsigned, WIDTH bits; a carry out of bit WIDTH-1 SHALL set overflow[in_chan], which stays set until clear on that channel or reset.
REQ-019 clear in RUN SHALL zero acc[in_chan] and overflow[in_chan] at the edge; with in_valid in the same cycle, the result SHALL be 0 + in (clear first, then add), overflow evaluated on that sum.
REQ-020 The FSM SHALL have states RUN and DUMP; the state after reset is RUN.
REQ-021 dump sampled high in RUN SHALL move to DUMP with index 0; a beat accepted in that same cycle SHALL be processed normally.
REQ-022 In DUMP each edge SHALL register out <= acc[index], out_chan <= index, out_valid <= 1, index <= index+1; after index CHANNELS-1 the FSM SHALL return to RUN.
REQ-023 DUMP SHALL last exactly CHANNELS cycles; in_ready SHALL be 0 throughout; in_valid, clear and dump SHALL be ignored; accumulators and flags SHALL be unchanged.
REQ-024 Accumulation on a channel SHALL not affect any other channel.

Reset
REQ-025 With reset high at a posedge: all accumulators 0, overflow 0, out 0, out_chan 0, out_valid 0, dump index 0, state RUN.
REQ-026 Reset SHALL take priority over every input, including mid-DUMP; in_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-027 Macro ACC_SATURATE_EN defined: an overflowing sum SHALL clamp to 2**WIDTH-1 and set the overflow flag.
REQ-028 ACC_SATURATE_EN undefined: the sum SHALL wrap modulo 2**WIDTH and set the overflow flag. All other behaviour is identical in both builds.

Verification (WIDTH=16, CH_W=2)
REQ-029 Scenario 1: reset high 2 cycles -> out=0, out_valid=0, overflow=4'b0000, in_ready=1.
REQ-030 Scenario 2: ch0 in=5 on two consecutive accepted edges -> out=5 then 10, out_chan=0, out_valid=1 each cycle, then 0 when in_valid drops.
REQ-031 Scenario 3: ch1 in=16'hFFF0 then in=16'h0020 -> out=16'h0010 and overflow=4'b0010 (wrap build); out=16'hFFFF and overflow=4'b0010 (ACC_SATURATE_EN build); acc[0] still 10.
REQ-032 Scenario 4: ch1 clear=1, in_valid=1, in=7 -> out=7, overflow[1]=0.
REQ-033 Scenario 5: one-cycle dump pulse with acc={0,0,7,10} -> 4 consecutive out_valid beats, out_chan 0..3, out 10,7,0,0; in_ready=0 for those 4 cycles; in_valid asserted during them leaves all accumulators unchanged.
REQ-034 Scenario 6: reset asserted at the 2nd DUMP cycle -> next cycle state RUN, out_valid=0, all accumulators and overflow 0, in_ready=1.
